writeback_queue: RTL and testbench

Buffered writeback unit that drives the write port of the integer register file (`isWrite`, `rd`, `writeData`). It accepts completed results from the execute/memory stages through a valid/ready handshake, queues them in order, and retires one per cycle into the register file. It also reports per-source-register pending-write hazards to the issue logic.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/wb_fifo.sv | 70 +++++++
 rtl/writeback_queue.sv | 85 ++++++++
 tb/tb_writeback_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared integer-datapath widths and the writeback entry type
// Revision: 1.0
// ============================================================================
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : in-order writeback entry storage with per-entry valid bits
// Revision: 1.0
// ============================================================================
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  wb_entry_t                 wr_entry,
  output wb_entry_t [DEPTH-1:0]     entries,
  output logic      [DEPTH-1:0]     valid,
  output logic [$clog2(DEPTH)-1:0]  head_ptr,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int c_AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic      [DEPTH-1:0] r_valid;
  logic [c_AW-1:0]       r_head;
  logic [c_AW-1:0]       r_tail;
  logic [c_AW:0]         r_count;

  // Payload needs no reset: r_valid and r_count gate every use of it.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_tail] <= wr_entry;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      // Set after clear so a full push+pop with head==tail keeps the slot valid.
      if (push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign entries  = r_mem;
  assign valid    = r_valid;
  assign head_ptr = r_head;
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == (c_AW+1)'(DEPTH));

endmodule : wb_fifo
`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// writeback_queue : buffered register-file writeback with hazard reporting
// Revision: 1.0
// ============================================================================
module writeback_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [REG_ADDR_W-1:0]   inRd,
  input  logic [XLEN-1:0]         inData,
  input  logic                    wbEnable,
  output logic                    isWrite,
  output logic [REG_ADDR_W-1:0]   rd,
  output logic [XLEN-1:0]         writeData,
  input  logic [REG_ADDR_W-1:0]   rs1,
  input  logic [REG_ADDR_W-1:0]   rs2,
  output logic                    rs1Busy,
  output logic                    rs2Busy,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] w_entries;
  logic      [DEPTH-1:0] w_valid;
  logic [c_AW-1:0]       w_head_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  wb_entry_t             w_wr_entry;
  wb_entry_t             w_head;
  logic                  w_rs1_hit;
  logic                  w_rs2_hit;

  assign inReady    = !w_full || (wbEnable && !w_empty);
  assign isWrite    = !w_empty && wbEnable;
  assign w_pop      = isWrite;
  // x0 results complete the handshake but are never stored.
  assign w_push     = inValid && inReady && (inRd != '0);
  assign w_wr_entry = '{rd: inRd, data: inData};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .pop      (w_pop),
    .wr_entry (w_wr_entry),
    .entries  (w_entries),
    .valid    (w_valid),
    .head_ptr (w_head_ptr),
    .count    (count),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign w_head    = w_entries[w_head_ptr];
  assign rd        = w_empty ? '0 : w_head.rd;
  assign writeData = w_empty ? '0 : w_head.data;

  // The draining head is bypassed by the register file, so it never counts.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && !(isWrite && (w_head_ptr == c_AW'(i)))) begin
        if (w_entries[i].rd == rs1) w_rs1_hit = 1'b1;
        if (w_entries[i].rd == rs2) w_rs2_hit = 1'b1;
      end
    end
  end

  assign rs1Busy = w_rs1_hit && (rs1 != '0);
  assign rs2Busy = w_rs2_hit && (rs2 != '0);

endmodule : writeback_queue
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// tb_writeback_queue : directed self-checking bench for writeback_queue
// Revision: 1.0
// ============================================================================
module tb_writeback_queue;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [4:0]  inRd;
  logic [31:0] inData;
  logic        wbEnable;
  logic        isWrite;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1Busy;
  logic        rs2Busy;
  logic [2:0]  count;

  int n_checks;
  int n_fails;

  writeback_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (inValid),
    .inReady   (inReady),
    .inRd      (inRd),
    .inData    (inData),
    .wbEnable  (wbEnable),
    .isWrite   (isWrite),
    .rd        (rd),
    .writeData (writeData),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1Busy   (rs1Busy),
    .rs2Busy   (rs2Busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] r, input logic [31:0] d);
    inValid = 1'b1;
    inRd    = r;
    inData  = d;
    tick();
    inValid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inRd     = '0;
    inData   = '0;
    wbEnable = 1'b1;
    rs1      = '0;
    rs2      = '0;
    #12;
    check("rst_count",   32'(count),   32'd0);
    check("rst_isWrite", 32'(isWrite), 32'd0);
    check("rst_rd",      32'(rd),      32'd0);
    check("rst_wdata",   writeData,    32'd0);
    check("rst_inReady", 32'(inReady), 32'd1);
    check("rst_busy",    32'({rs1Busy, rs2Busy}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single write
    offer(5'd5, 32'hDEADBEEF);
    #1;
    check("single_isWrite", 32'(isWrite), 32'd1);
    check("single_rd",      32'(rd),      32'd5);
    check("single_wdata",   writeData,    32'hDEADBEEF);
    check("single_count1",  32'(count),   32'd1);
    tick();
    check("single_count0",  32'(count),   32'd0);
    check("single_idle",    32'(isWrite), 32'd0);

    // x0 discard
    inValid = 1'b1; inRd = 5'd0; inData = 32'h1234;
    #1;
    check("x0_inReady", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    #1;
    check("x0_isWrite", 32'(isWrite), 32'd0);
    check("x0_count",   32'(count),   32'd0);

    // Fill while frozen
    wbEnable = 1'b0;
    for (int i = 1; i <= 4; i++) offer(5'(i), 32'(i * 16));
    rs1 = 5'd3; rs2 = 5'd1;
    #1;
    check("fill_count",   32'(count),   32'd4);
    check("fill_inReady", 32'(inReady), 32'd0);
    check("fill_isWrite", 32'(isWrite), 32'd0);
    check("fill_rs1Busy", 32'(rs1Busy), 32'd1);
    check("fill_headBusy_frozen", 32'(rs2Busy), 32'd1);

    // Release with push+pop on the full queue
    wbEnable = 1'b1;
    inValid = 1'b1; inRd = 5'd9; inData = 32'h90;
    #1;
    check("full_inReady", 32'(inReady), 32'd1);
    check("drain1_rd",    32'(rd),      32'd1);
    check("drain1_wdata", writeData,    32'h10);
    check("drain_headBusy_excl", 32'(rs2Busy), 32'd0);
    tick();
    inValid = 1'b0;
    check("pushpop_count", 32'(count), 32'd4);
    check("drain2_rd",     32'(rd),    32'd2);
    check("drain2_wdata",  writeData,  32'h20);
    tick();
    check("drain3_rd", 32'(rd), 32'd3);
    tick();
    check("drain4_rd", 32'(rd), 32'd4);
    tick();
    check("drain5_rd",    32'(rd),   32'd9);
    check("drain5_wdata", writeData, 32'h90);
    tick();
    check("drain_empty", 32'(count), 32'd0);
    check("drain_idle",  32'(isWrite), 32'd0);

    // Hazard on the same destination twice
    rs1 = 5'd7; rs2 = 5'd0;
    wbEnable = 1'b0;
    inValid = 1'b1; inRd = 5'd7; inData = 32'hA;
    #1;
    check("haz_offer_not_busy", 32'(rs1Busy), 32'd0);
    tick();
    offer(5'd7, 32'hB);
    wbEnable = 1'b1;
    #1;
    check("haz_A_wdata", writeData,    32'hA);
    check("haz_A_busy",  32'(rs1Busy), 32'd1);
    check("haz_rs2_x0",  32'(rs2Busy), 32'd0);
    tick();
    check("haz_B_wdata", writeData,    32'hB);
    check("haz_B_busy",  32'(rs1Busy), 32'd0);
    tick();
    check("haz_empty_busy", 32'(rs1Busy), 32'd0);

    // Reset mid-operation
    wbEnable = 1'b0;
    offer(5'd10, 32'h100);
    offer(5'd11, 32'h110);
    offer(5'd12, 32'h120);
    rs1 = 5'd10; rs2 = 5'd12;
    wbEnable = 1'b1;
    #1;
    check("pre_rst_count",   32'(count),   32'd3);
    check("pre_rst_isWrite", 32'(isWrite), 32'd1);
    check("pre_rst_rs2Busy", 32'(rs2Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_isWrite", 32'(isWrite), 32'd0);
    check("mid_rst_count",   32'(count),   32'd0);
    check("mid_rst_busy",    32'({rs1Busy, rs2Busy}), 32'd0);
    check("mid_rst_rd",      32'(rd),      32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_stale", 32'(isWrite), 32'd0);
    end

    offer(5'd13, 32'h55);
    #1;
    check("post_rst_rd",    32'(rd),   32'd13);
    check("post_rst_wdata", writeData, 32'h55);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_writeback_queue
`default_nettype wire
